// File: rtl/pipe_addsub_if.sv
// Operand/result handshake bundle for pipe_addsub: one input beat channel and one
// result channel, both valid/ready.
interface pipe_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero, neg
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero, neg
    );
endinterface

// File: rtl/pipe_addsub.sv
// Carry-pipelined adder/subtractor: each stage adds one WIDTH/STAGES-bit slice and
// hands its carry to the next; the last stage register is the result register.
module pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int SAT    = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    pipe_addsub_if.slave  bus
);
    localparam int SL = WIDTH / STAGES;
    localparam int PS = (STAGES > 1) ? STAGES - 1 : 1;

    localparam logic signed [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Overflowing operands share a sign, so A's MSB tells which rail to clamp to.
    function automatic logic [WIDTH-1:0] sat_fn(input logic [WIDTH-1:0] raw,
                                                 input logic ov,
                                                 input logic a_msb);
        if (SAT != 0 && ov)
            return a_msb ? MIN_NEG : MAX_POS;
        return raw;
    endfunction

    // Skew registers between stages (index k = output of stage k).
    logic             vld_p [PS];
    logic [WIDTH-1:0] a_p   [PS];
    logic [WIDTH-1:0] bx_p  [PS];
    logic [WIDTH-1:0] s_p   [PS];
    logic             cy_p  [PS];

    logic             vld_out;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic             op_v  [STAGES];
    logic [WIDTH-1:0] op_a  [STAGES];
    logic [WIDTH-1:0] op_b  [STAGES];
    logic [WIDTH-1:0] op_s  [STAGES];
    logic             op_c  [STAGES];
    logic [SL:0]      slc_r [STAGES];
    logic [WIDTH-1:0] nx_s  [STAGES];
    logic             nx_c  [STAGES];

    logic             en;
    logic [WIDTH-1:0] raw_sum;
    logic             msb_cin;
    logic             raw_ovf;

    assign en = !vld_out || bus.out_ready;

    always_comb begin
        op_v[0] = bus.in_valid;
        op_a[0] = bus.a;
        op_b[0] = bus.b ^ {WIDTH{bus.sub}};
        op_s[0] = '0;
        op_c[0] = bus.sub;
        for (int k = 1; k < STAGES; k++) begin
            op_v[k] = vld_p[k-1];
            op_a[k] = a_p[k-1];
            op_b[k] = bx_p[k-1];
            op_s[k] = s_p[k-1];
            op_c[k] = cy_p[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            slc_r[k] = {1'b0, op_a[k][k*SL +: SL]} + {1'b0, op_b[k][k*SL +: SL]}
                     + {{SL{1'b0}}, op_c[k]};
            nx_s[k]  = op_s[k];
            nx_s[k][k*SL +: SL] = slc_r[k][SL-1:0];
            nx_c[k]  = slc_r[k][SL];
        end
    end

    // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
    assign raw_sum = nx_s[STAGES-1];
    assign msb_cin = raw_sum[WIDTH-1] ^ op_a[STAGES-1][WIDTH-1] ^ op_b[STAGES-1][WIDTH-1];
    assign raw_ovf = msb_cin ^ nx_c[STAGES-1];

    // Stage boundaries: valid bits and the result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < PS; k++)
                vld_p[k] <= 1'b0;
            vld_out <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < STAGES - 1; k++)
                vld_p[k] <= op_v[k];
            vld_out <= op_v[STAGES-1];
            if (op_v[STAGES-1]) begin
                sum_q  <= sat_fn(raw_sum, raw_ovf, op_a[STAGES-1][WIDTH-1]);
                cout_q <= nx_c[STAGES-1];
                ovf_q  <= raw_ovf;
            end
        end
    end

    // Stage boundaries: operand and partial-sum skew data.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                a_p[k]  <= op_a[k];
                bx_p[k] <= op_b[k];
                s_p[k]  <= nx_s[k];
                cy_p[k] <= nx_c[k];
            end
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = vld_out;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = (sum_q == '0);
    assign bus.neg       = sum_q[WIDTH-1];
endmodule

// File: tb/tb_pipe_addsub.sv
// Directed bench for pipe_addsub: a wrap-around and a saturating instance are driven
// with identical beats and compared against hand-computed results.
module tb_pipe_addsub;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    pipe_addsub_if #(.WIDTH(32)) bw ();
    pipe_addsub_if #(.WIDTH(32)) bs ();

    pipe_addsub #(.WIDTH(32), .STAGES(4), .SAT(0)) dut_w (.clk(clk), .rst_n(rst_n), .bus(bw));
    pipe_addsub #(.WIDTH(32), .STAGES(4), .SAT(1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bs));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic ordy);
        bw.in_valid = v;  bw.a = a;  bw.b = b;  bw.sub = s;  bw.out_ready = ordy;
        bs.in_valid = v;  bs.a = a;  bs.b = b;  bs.sub = s;  bs.out_ready = ordy;
    endtask

    // Called on a falling edge; offers one beat and checks it lands exactly 4 cycles later.
    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [31:0] exp_w, input logic [31:0] exp_s,
                           input logic exp_c, input logic exp_o);
        drive(1'b1, a, b, s, 1'b1);
        #1;
        chk({tag, "_in_ready"}, bw.in_ready, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_early_valid"}, bw.out_valid, 1'b0);
            @(negedge clk);
        end
        chk({tag, "_w_valid"}, bw.out_valid, 1'b1);
        chk({tag, "_w_sum"},   bw.sum,  exp_w);
        chk({tag, "_w_cout"},  bw.cout, exp_c);
        chk({tag, "_w_ovf"},   bw.ovf,  exp_o);
        chk({tag, "_w_zero"},  bw.zero, exp_w == 32'h0);
        chk({tag, "_w_neg"},   bw.neg,  exp_w[31]);
        chk({tag, "_s_valid"}, bs.out_valid, 1'b1);
        chk({tag, "_s_sum"},   bs.sum,  exp_s);
        chk({tag, "_s_cout"},  bs.cout, exp_c);
        chk({tag, "_s_ovf"},   bs.ovf,  exp_o);
        chk({tag, "_s_zero"},  bs.zero, exp_s == 32'h0);
        chk({tag, "_s_neg"},   bs.neg,  exp_s[31]);
        @(negedge clk);
        chk({tag, "_bubble"}, bw.out_valid, 1'b0);
    endtask

    // Ten back-to-back beats; the consumer stalls on output cycles 3..7.
    task automatic stream_test();
        logic [31:0] exp_q[$];
        logic [31:0] va, vb;
        logic        vs, stall;
        int          sent, got, ocyc, cyc;
        sent = 0;  got = 0;  ocyc = -1;  cyc = 0;
        while (got < 10 && cyc < 80) begin
            if (ocyc >= 0)
                ocyc++;
            else if (bw.out_valid)
                ocyc = 0;
            stall = (ocyc >= 3 && ocyc <= 7);
            va = 32'h0010_FFFF + 32'h0010_0000 * sent;
            vb = 32'h0000_0011 + sent;
            vs = sent[0];
            drive(sent < 10, va, vb, vs, !stall);
            #1;
            chk("stream_in_ready_w", bw.in_ready, !stall);
            chk("stream_in_ready_s", bs.in_ready, !stall);
            if (bw.out_valid) begin
                chk("stream_sum_w", bw.sum, (got < exp_q.size()) ? exp_q[got] : 32'hDEAD_BEEF);
                chk("stream_sum_s", bs.sum, (got < exp_q.size()) ? exp_q[got] : 32'hDEAD_BEEF);
                if (!stall)
                    got++;
            end
            if (sent < 10 && !stall) begin
                exp_q.push_back(vs ? va - vb : va + vb);
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("stream_done", got, 10);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("stream_no_extra", bw.out_valid, 1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", bw.out_valid, 1'b0);
        chk("rst_sum",       bw.sum, 32'h0);
        chk("rst_cout",      bw.cout, 1'b0);
        chk("rst_ovf",       bw.ovf, 1'b0);
        chk("rst_neg",       bw.neg, 1'b0);
        chk("rst_zero",      bw.zero, 1'b1);
        chk("rst_in_ready",  bw.in_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_one("add_5_3",    32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 32'h0000_0008, 1'b0, 1'b0);
        run_one("pos_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1);
        run_one("sub_5_5",    32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
        run_one("sub_3_5",    32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_one("neg_ovf",    32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
        run_one("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
        run_one("slice_cy",   32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 32'h0100_0000, 1'b0, 1'b0);
        run_one("mixed",      32'h1234_5678, 32'h0FED_CBA8, 1'b0, 32'h2222_2220, 32'h2222_2220, 1'b0, 1'b0);

        stream_test();

        // Four beats in: one presented, three in flight, then reset hits.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h0000_00A0 + i, 32'h0000_0001, 1'b0, 1'b1);
            @(negedge clk);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("pre_rst_valid", bw.out_valid, 1'b1);
        chk("pre_rst_sum",   bw.sum, 32'h0000_00A1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",    bw.out_valid, 1'b0);
        chk("mid_rst_sum",      bw.sum, 32'h0);
        chk("mid_rst_zero",     bw.zero, 1'b1);
        chk("mid_rst_in_ready", bw.in_ready, 1'b1);
        chk("mid_rst_valid_s",  bs.out_valid, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("post_rst_stale", bw.out_valid, 1'b0);
            @(negedge clk);
        end
        run_one("post_rst", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_chk, n_err);
        $fatal(1);
    end
endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; SHALL be >= 4.
REQ-002 Parameter STAGES, default 4: pipeline depth; WIDTH SHALL be an integer multiple of STAGES; each stage handles one WIDTH/STAGES-bit slice.
REQ-003 Parameter SAT, default 0: 1 selects signed saturation on overflow; 0 selects wrap-around.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  operand beat offered.
REQ-007 in_ready  output  1  block accepts the beat this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 sub  input  1  0 = A+B; 1 = A-B, computed as A + ~B + 1.
REQ-011 out_valid  output  1  result beat presented.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry out of MSB; for sub, 1 = no borrow.
REQ-015 ovf  output  1  signed overflow of the unsaturated result.
REQ-016 zero  output  1  sum (as presented) equals 0.
REQ-017 neg  output  1  MSB of sum as presented.

Function
REQ-018 Beat transfer on input SHALL occur when in_valid && in_ready; on output when out_valid && out_ready.
REQ-019 Pipeline advance enable SHALL be en = !out_valid || out_ready; in_ready SHALL equal en (combinational, no dependence on in_valid).
REQ-020 When en = 0 every stage register, including valid bits, SHALL hold; sum and flags SHALL stay stable while out_valid && !out_ready.
REQ-021 Stage k (0..STAGES-1) SHALL add slice k of A and B-xor-sub using the carry registered by stage k-1 (stage 0 carry-in = sub); upper slices and lower partial sums SHALL be carried forward in skew registers.
REQ-022 Latency SHALL be exactly STAGES cycles from an accepted beat to its out_valid, with no stalls; throughput one beat per cycle while out_ready = 1.
REQ-023 A bubble (en = 1, in_valid = 0) SHALL propagate as a 0 valid bit; results SHALL leave in acceptance order, none dropped or duplicated.
REQ-024 ovf SHALL be carry-into-MSB XOR carry-out-of-MSB of the final slice.
REQ-025 SAT = 1 with ovf = 1: sum SHALL be 0x7FF..F if true result is positive (A MSB = 0), 0x800..0 if negative; cout and ovf SHALL reflect the unsaturated add; zero/neg SHALL reflect the saturated sum.
REQ-026 SAT = 0: sum SHALL be the low WIDTH bits (wrap-around).
REQ-027 zero and neg SHALL be derived from the output register contents, not recomputed from inputs.
REQ-028 Simultaneous output pop and input push in one cycle SHALL both occur with the pipeline full (no bubble inserted).

Reset
REQ-029 rst_n = 0 SHALL immediately clear all valid bits; out_valid = 0, sum = 0, cout = 0, ovf = 0, neg = 0, zero = 1 (zero reflects cleared sum).
REQ-030 Reset mid-operation SHALL discard all in-flight beats; no result of a pre-reset beat SHALL appear after release.
REQ-031 in_ready SHALL be 1 during and immediately after reset (out_valid = 0).

Verification (WIDTH=32, STAGES=4)
REQ-032 a=0x0000_0005, b=0x0000_0003, sub=0, out_ready=1 -> exactly 4 cycles later sum=0x8, cout=0, ovf=0, zero=0, neg=0.
REQ-033 a=0x7FFF_FFFF, b=1, sub=0: SAT=0 -> sum=0x8000_0000, ovf=1, neg=1; SAT=1 -> sum=0x7FFF_FFFF, ovf=1, neg=0.
REQ-034 a=5, b=5, sub=1 -> sum=0, cout=1, zero=1; a=3, b=5, sub=1 -> sum=0xFFFF_FFFE, cout=0, neg=1.
REQ-035 Stream 10 back-to-back beats, out_ready held 0 for cycles 3-7 -> in_ready=0 in those cycles, output order matches input order, no beat lost or repeated, sum stable while stalled.
REQ-036 Assert rst_n=0 with 3 beats in flight -> out_valid=0 immediately, no stale result after release; next beat a=0xFFFF_FFFF, b=1 -> sum=0, cout=1, zero=1 after 4 cycles.
